seq_framer: RTL and testbench

Transmit-side framer for the byte-stream sync protocol. Prepends the fixed 4-byte sync header AA, AA, FF, CF to each block of PAYLOAD_LEN payload bytes, and drives a registered byte stream with valid/ready flow control. Sits between the payload source and the link whose receive end runs the sync-sequence detector. Whole frames only: a frame, once started, always completes.

---
 rtl/seq_framer.sv | 135 +++++++++++++
 tb/tb_seq_framer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_framer.sv
// Transmit framer: prepends the 4-byte sync header to each PAYLOAD_LEN-byte block
// and drives a registered valid/ready byte stream.
module seq_framer #(
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter logic [7:0]  SYNC0       = 8'hAA,
  parameter logic [7:0]  SYNC1       = 8'hAA,
  parameter logic [7:0]  SYNC2       = 8'hFF,
  parameter logic [7:0]  SYNC3       = 8'hCF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  data_in,
  input  logic        data_valid_in,
  output logic        data_ready_out,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  input  logic        data_ready_in,
  output logic        frame_start_out,
  output logic        frame_done_out,
  output logic [15:0] frame_count
);

  localparam int unsigned CW = 8;
  localparam int unsigned KW = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;
  logic [CW-1:0]   c, c_nxt;
  logic [7:0]      data_out_nxt;
  logic            valid_nxt;
  logic            start_nxt;
  logic            done_nxt;
  logic [15:0]     frame_count_nxt;
  logic            load_en;
  logic [7:0]      sync_byte;

  // Output register may load whenever it is empty or being consumed
  assign load_en = !data_valid_out || data_ready_in;

  always_comb begin
    sync_byte = SYNC0;
    case (k)
      2'd0:    sync_byte = SYNC0;
      2'd1:    sync_byte = SYNC1;
      2'd2:    sync_byte = SYNC2;
      default: sync_byte = SYNC3;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      k               <= '0;
      c               <= '0;
      data_out        <= 8'h00;
      data_valid_out  <= 1'b0;
      frame_start_out <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_count     <= 16'h0000;
    end else begin
      state           <= state_nxt;
      k               <= k_nxt;
      c               <= c_nxt;
      data_out        <= data_out_nxt;
      data_valid_out  <= valid_nxt;
      frame_start_out <= start_nxt;
      frame_done_out  <= done_nxt;
      frame_count     <= frame_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    k_nxt           = k;
    c_nxt           = c;
    data_out_nxt    = data_out;
    valid_nxt       = data_valid_out;
    start_nxt       = 1'b0;
    done_nxt        = 1'b0;
    frame_count_nxt = frame_count;
    data_ready_out  = 1'b0;

    case (state)
      IDLE: begin
        if (load_en) valid_nxt = 1'b0;
        if (enable && data_valid_in) begin
          state_nxt = SYNC;
          k_nxt     = '0;
          start_nxt = 1'b1;
        end
      end

      SYNC: begin
        if (load_en) begin
          data_out_nxt = sync_byte;
          valid_nxt    = 1'b1;
          k_nxt        = k + KW'(1);
          if (k == KW'(3)) begin
            state_nxt = PAYLOAD;
            c_nxt     = '0;
          end
        end
      end

      PAYLOAD: begin
        data_ready_out = load_en;
        if (data_valid_in && load_en) begin
          data_out_nxt = data_in;
          valid_nxt    = 1'b1;
          if (c == CW'(PAYLOAD_LEN - 1)) begin
            state_nxt       = IDLE;
            c_nxt           = '0;
            done_nxt        = 1'b1;
            frame_count_nxt = frame_count + 16'd1;
          end else begin
            c_nxt = c + CW'(1);
          end
        end else if (load_en) begin
          // Source bubble: drain the register, keep the payload index
          valid_nxt = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_framer.sv
// Scoreboard bench for seq_framer: expected bytes are queued as frames are driven
// and popped on every accepted output beat.
module tb_seq_framer;

  localparam int unsigned PL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  data_in;
  logic        data_valid_in;
  logic        data_ready_out;
  logic [7:0]  data_out;
  logic        data_valid_out;
  logic        data_ready_in;
  logic        frame_start_out;
  logic        frame_done_out;
  logic [15:0] frame_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] exp_count = 16'h0000;
  logic [7:0]  exp_q [$];
  logic        held_pending = 1'b0;
  logic [7:0]  held_byte = 8'h00;
  logic        prev_start = 1'b0;

  always #5 clk = ~clk;

  seq_framer #(.PAYLOAD_LEN(PL)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .data_in         (data_in),
    .data_valid_in   (data_valid_in),
    .data_ready_out  (data_ready_out),
    .data_out        (data_out),
    .data_valid_out  (data_valid_out),
    .data_ready_in   (data_ready_in),
    .frame_start_out (frame_start_out),
    .frame_done_out  (frame_done_out),
    .frame_count     (frame_count)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return cyc[0];
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // Output monitor: beat order, hold stability, pulses and frame counter
  initial forever begin
    @(negedge clk);
    if (reset) begin
      held_pending = 1'b0;
      prev_start   = 1'b0;
    end else begin
      if (held_pending) begin
        check_eq("hold_valid", 16'(data_valid_out), 16'd1);
        check_eq("hold_byte", 16'(data_out), 16'(held_byte));
      end
      held_pending = 1'b0;
      if (data_valid_out && data_ready_in) begin
        check_eq("beat_expected", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) check_eq("beat_byte", 16'(data_out), 16'(exp_q.pop_front()));
      end else if (data_valid_out) begin
        held_pending = 1'b1;
        held_byte    = data_out;
      end
      if (frame_start_out) begin
        start_cnt++;
        check_eq("start_pulse_len", 16'(prev_start), 16'd0);
      end
      if (frame_start_out || frame_done_out)
        check_eq("start_done_excl", 16'(frame_start_out & frame_done_out), 16'd0);
      if (frame_done_out) begin
        done_cnt++;
        exp_count = exp_count + 16'd1;
        check_eq("frame_count", frame_count, exp_count);
      end
      prev_start = frame_start_out;
    end
  end

  // Queue one frame's expected bytes, then feed its payload and drain the output
  task automatic send_frame(input logic [31:0] pay, input int mode, input int bubble_at,
                            input int drop_en_at);
    int   idx = 0;
    int   cyc = 0;
    int   bub = 0;
    int   guard = 0;
    logic gap = 1'b0;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hCF);
    for (int i = 0; i < int'(PL); i++) exp_q.push_back(pay[31-8*i -: 8]);
    enable = 1'b1;
    while (idx < int'(PL) && cyc < 200) begin
      if (cyc == drop_en_at) enable = 1'b0;
      data_valid_in = (bub == 0);
      data_in       = pay[31-8*idx -: 8];
      data_ready_in = ready_for(mode, cyc);
      @(negedge clk);
      if (bub > 0 && !data_valid_out) gap = 1'b1;
      if (data_valid_in && data_ready_out) begin
        if (idx == bubble_at) bub = 3;
        idx++;
      end else if (!data_valid_in) begin
        bub--;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("src_accepted", 16'(idx), 16'(PL));
    data_valid_in = 1'b0;
    while (exp_q.size() != 0 && guard < 100) begin
      data_ready_in = ready_for(mode, cyc);
      @(posedge clk);
      #1;
      cyc++;
      guard++;
    end
    check_eq("drain", 16'(exp_q.size()), 16'd0);
    if (bubble_at >= 0) check_eq("bubble_gap", 16'(gap), 16'd1);
    data_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int   s0;
    int   d0;
    logic found;
    reset         = 1'b1;
    enable        = 1'b0;
    data_in       = 8'h00;
    data_valid_in = 1'b0;
    data_ready_in = 1'b1;
    #1;
    check_eq("rst_data_out", 16'(data_out), 16'h0000);
    check_eq("rst_valid", 16'(data_valid_out), 16'd0);
    check_eq("rst_ready", 16'(data_ready_out), 16'd0);
    check_eq("rst_count", frame_count, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic frame
    send_frame(32'h11223344, 0, -1, -1);
    check_eq("basic_starts", 16'(start_cnt), 16'd1);
    check_eq("basic_dones", 16'(done_cnt), 16'd1);
    check_eq("basic_count", frame_count, 16'd1);

    // Toggling backpressure
    send_frame(32'h11223344, 1, -1, -1);
    check_eq("bp_count", frame_count, 16'd2);

    // Source bubble after first payload byte
    send_frame(32'h11223344, 0, 0, -1);

    // Payload that mimics sync bytes, random backpressure
    send_frame(32'hAACFFF00, 2, -1, -1);

    // Enable dropped mid-frame: frame completes, no restart
    send_frame(32'h5A6B7C8D, 0, -1, 3);
    s0 = start_cnt;
    data_valid_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("no_restart", 16'(start_cnt), 16'(s0));
    check_eq("idle_valid", 16'(data_valid_out), 16'd0);
    data_valid_in = 1'b0;
    send_frame(32'h01020304, 0, -1, -1);
    check_eq("reenable_start", 16'(start_cnt), 16'(s0 + 1));

    // Reset while FF is held under backpressure
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hFF);
    found = 1'b0;
    enable        = 1'b1;
    data_in       = 8'h55;
    data_valid_in = 1'b1;
    data_ready_in = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (data_valid_out && data_out == 8'hFF) found = 1'b1;
    end
    data_ready_in = 1'b0;
    check_eq("ff_reached", 16'(found), 16'd1);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 16'(data_valid_out), 16'd0);
    check_eq("mid_rst_data", 16'(data_out), 16'h0000);
    check_eq("mid_rst_ready", 16'(data_ready_out), 16'd0);
    check_eq("mid_rst_start", 16'(frame_start_out), 16'd0);
    check_eq("mid_rst_done", 16'(frame_done_out), 16'd0);
    check_eq("mid_rst_count", frame_count, 16'h0000);
    data_valid_in = 1'b0;
    data_ready_in = 1'b1;
    exp_q.delete();
    exp_count = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    d0 = done_cnt;
    send_frame(32'hDEADBEEF, 0, -1, -1);
    check_eq("post_rst_count", frame_count, 16'd1);

    // Counter wrap from a preloaded FFFF
    @(negedge clk);
    force dut.frame_count_nxt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_nxt;
    exp_count = 16'hFFFF;
    check_eq("preload", frame_count, 16'hFFFF);
    send_frame(32'h99887766, 0, -1, -1);
    check_eq("wrap_count", frame_count, 16'h0000);
    check_eq("wrap_done", 16'(done_cnt), 16'(d0 + 2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
